mips_bus_arb: RTL and testbench
===============================

MIPS_BUS_ARB -- requirements
Module: mips_bus_arb

Interface
REQ-001 Parameters: IFIRST, default 0, serve instruction before data when both pending; NOP, default 32'h0, value of op after reset.
REQ-002 Clock is single; reset is synchronous and active-high.
REQ-003 clock  in  1  system clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ireq  in  1  core requests instruction fetch this cycle.
REQ-006 PC  in  32  fetch address, word aligned.
REQ-007 op  out  32  fetched instruction, registered.
REQ-008 DA  in  32  data word address, bits [1:0] zero.
REQ-009 we  in  4  data byte write enables.
REQ-010 DO  in  32  data to store.
REQ-011 re  in  1  data read request.
REQ-012 DI  out  32  loaded word, registered.
REQ-013 hold  out  1  core SHALL freeze all pipeline registers while high.
REQ-014 MA  out  32  memory address.
REQ-015 MW  out  4  memory byte write enables; 0 means read.
REQ-016 MO  out  32  memory write data.
REQ-017 mreq  out  1  memory request.
REQ-018 MI  in  32  memory read data, valid with mack.
REQ-019 mack  in  1  memory acknowledge, one cycle per transfer.

Function
REQ-020 The data request is dreq = re | (|we); the block shares one memory port between the fetch and data sides.
REQ-021 The FSM SHALL have states IDLE, DATA, INST and DONE.
REQ-022 IDLE: if neither ireq nor dreq is asserted, stay in IDLE.
REQ-023 IDLE with requests: latch the pending set {ip=ireq, dp=dreq} and the operands PC, DA, we, DO.
REQ-024 IDLE with requests, next state: DATA when dp & (!IFIRST | !ip); otherwise INST.
REQ-025 DATA/INST: mreq=1, with MA/MW/MO driven from the latched operands; MW=0 in INST and on data reads.
REQ-026 Hold the DATA/INST state until mack, keeping MA/MW/MO/mreq stable.
REQ-027 On mack in DATA: if re was latched, DI<=MI.
REQ-028 On mack in INST: op<=MI.
REQ-029 On mack, clear the served pending bit; go to the other state if its bit is still set, else go to DONE.
REQ-030 DONE: mreq=0 and hold=0; requests seen in DONE are ignored; next state IDLE.
REQ-031 hold=1 in IDLE whenever ireq|dreq is asserted, and throughout DATA and INST.
REQ-032 hold=0 in IDLE when no request is asserted, and in DONE.
REQ-033 Minimum latency (zero-wait memory): single access, request in cycle 0, mreq in cycle 1, mack in cycle 1, hold low in cycle 2.
REQ-034 Minimum latency (zero-wait memory): dual access, hold low in cycle 3.
REQ-035 mack outside DATA/INST SHALL be ignored.
REQ-036 A write-only data access SHALL leave DI unchanged.
REQ-037 Request inputs that change while in DATA/INST SHALL NOT affect the transaction in flight.

Reset
REQ-038 Reset SHALL take the FSM to IDLE and clear ip/dp.
REQ-039 Reset SHALL drive mreq=0, MW=0, hold=0, op=NOP and DI=0 in the following cycle.
REQ-040 Reset during DATA/INST SHALL abandon the transfer; the memory SHALL tolerate mreq falling before mack.
REQ-041 op and DI SHALL be updated only on mack and on reset.

Structure
REQ-042 The state encoding (2 bits) and NOP SHALL be shared localparams in the mips core package header, reused by mips_if.
REQ-043 The block SHALL be one module with no sub-modules; the operand latch is an internal register group.

Verification
REQ-044 Fetch only: ireq=1, PC=0x100, MI=0x24010005, zero wait → mreq cycle 1, MA=0x100, MW=0; op=0x24010005 and hold=0 in cycle 2.
REQ-045 Both pending, IFIRST=0: store we=4'hF, DA=0x200, DO=0xDEADBEEF, plus fetch PC=0x104 → DATA first with MW=F, MO=0xDEADBEEF, then INST with MA=0x104; hold low in cycle 3.
REQ-046 Wait states: load re=1, DA=0x300, mack delayed 3 cycles, MI=0x12345678 → MA stable and hold=1 throughout; DI=0x12345678 the cycle after mack.
REQ-047 DONE gap: ireq held high continuously → no mreq in the DONE cycle; a new transaction starts in the following IDLE cycle.
REQ-048 Reset in INST before mack → the next cycle has mreq=0, hold=0, op=NOP; a late mack is ignored.
REQ-049 IFIRST=1 with both pending → INST precedes DATA; final op and DI match the memory contents.

Source files
------------

// File: rtl/mips_bus_arb_pkg.sv
// Shared definitions for the MIPS core memory-bus side: arbiter state encoding and the
// instruction word presented on op after reset.
package mips_bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_DATA = 2'd1,
    ARB_INST = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_t;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/mips_bus_arb.sv
// Shares a single memory port between the instruction-fetch and data sides of the core,
// stalling the pipeline through hold until every pending access has been served.
module mips_bus_arb
  import mips_bus_arb_pkg::*;
#(
  parameter bit          IFIRST = 1'b0,
  parameter logic [31:0] NOP    = MIPS_NOP
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ireq,
  input  logic [31:0] PC,
  output logic [31:0] op,
  input  logic [31:0] DA,
  input  logic [3:0]  we,
  input  logic [31:0] DO,
  input  logic        re,
  output logic [31:0] DI,
  output logic        hold,
  output logic [31:0] MA,
  output logic [3:0]  MW,
  output logic [31:0] MO,
  output logic        mreq,
  input  logic [31:0] MI,
  input  logic        mack
);

  arb_state_t  state_q;
  logic        ip_q, dp_q, rd_q;
  logic [31:0] pc_q, da_q, do_q;
  logic [3:0]  we_q;
  logic [31:0] op_q, di_q;
  logic        dreq;

  assign dreq = re | (|we);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      ip_q    <= 1'b0;
      dp_q    <= 1'b0;
      rd_q    <= 1'b0;
      pc_q    <= '0;
      da_q    <= '0;
      we_q    <= '0;
      do_q    <= '0;
      op_q    <= NOP;
      di_q    <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (ireq | dreq) begin
            ip_q    <= ireq;
            dp_q    <= dreq;
            rd_q    <= re;
            pc_q    <= PC;
            da_q    <= DA;
            we_q    <= we;
            do_q    <= DO;
            state_q <= (dreq && (!IFIRST || !ireq)) ? ARB_DATA : ARB_INST;
          end
        end
        ARB_DATA: begin
          if (mack) begin
            if (rd_q) di_q <= MI;
            dp_q    <= 1'b0;
            state_q <= ip_q ? ARB_INST : ARB_DONE;
          end
        end
        ARB_INST: begin
          if (mack) begin
            op_q    <= MI;
            ip_q    <= 1'b0;
            state_q <= dp_q ? ARB_DATA : ARB_DONE;
          end
        end
        ARB_DONE: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from the registered state and operand latch, so they
  // cannot move while a transfer waits for mack.
  always_comb begin
    mreq = 1'b0;
    MW   = '0;
    MA   = da_q;
    hold = 1'b0;
    case (state_q)
      ARB_IDLE: hold = ireq | dreq;
      ARB_DATA: begin
        mreq = 1'b1;
        hold = 1'b1;
        MW   = we_q;
      end
      ARB_INST: begin
        mreq = 1'b1;
        hold = 1'b1;
        MA   = pc_q;
      end
      default: ;
    endcase
  end

  assign MO = do_q;
  assign op = op_q;
  assign DI = di_q;

endmodule

// File: tb/tb_mips_bus_arb.sv
// Directed bench for mips_bus_arb: one instance with data-first priority, one with
// instruction-first priority, sharing the core-side stimulus.
module tb_mips_bus_arb;

  logic        clock = 1'b0;
  logic        reset, ireq, re, mack;
  logic [31:0] PC, DA, DO, mi0, mi1;
  logic [3:0]  we;

  logic [31:0] op0, di0, ma0, mo0, op1, di1, ma1, mo1;
  logic [3:0]  mw0, mw1;
  logic        hold0, mreq0, hold1, mreq1;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP1 = 32'h0BAD_0001;

  always #5 clock = ~clock;

  mips_bus_arb u_dut0 (
    .clock(clock), .reset(reset), .ireq(ireq), .PC(PC), .op(op0), .DA(DA), .we(we),
    .DO(DO), .re(re), .DI(di0), .hold(hold0), .MA(ma0), .MW(mw0), .MO(mo0),
    .mreq(mreq0), .MI(mi0), .mack(mack)
  );

  mips_bus_arb #(.IFIRST(1'b1), .NOP(NOP1)) u_dut1 (
    .clock(clock), .reset(reset), .ireq(ireq), .PC(PC), .op(op1), .DA(DA), .we(we),
    .DO(DO), .re(re), .DI(di1), .hold(hold1), .MA(ma1), .MW(mw1), .MO(mo1),
    .mreq(mreq1), .MI(mi1), .mack(mack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle one step past the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; ireq = 1'b0; re = 1'b0; mack = 1'b0;
    PC = '0; DA = '0; DO = '0; we = '0; mi0 = '0; mi1 = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_mreq", {31'd0, mreq0}, 32'd0);
    chk("rst_mw",   {28'd0, mw0},   32'd0);
    chk("rst_hold", {31'd0, hold0}, 32'd0);
    chk("rst_op",   op0, 32'h0);
    chk("rst_di",   di0, 32'h0);
    chk("rst_op1",  op1, NOP1);

    // Fetch only, zero-wait memory
    ireq = 1'b1; PC = 32'h100;
    #1;
    chk("f_c0_hold", {31'd0, hold0}, 32'd1);
    chk("f_c0_mreq", {31'd0, mreq0}, 32'd0);
    tick();
    chk("f_c1_mreq", {31'd0, mreq0}, 32'd1);
    chk("f_c1_ma",   ma0, 32'h100);
    chk("f_c1_mw",   {28'd0, mw0}, 32'd0);
    ireq = 1'b0; mack = 1'b1; mi0 = 32'h2401_0005; mi1 = 32'h2401_0005;
    tick();
    chk("f_c2_op",   op0, 32'h2401_0005);
    chk("f_c2_hold", {31'd0, hold0}, 32'd0);
    chk("f_c2_mreq", {31'd0, mreq0}, 32'd0);

    // Stray mack in DONE and IDLE must not touch op/DI
    mi0 = 32'hAAAA_AAAA;
    tick();
    tick();
    chk("stray_op",   op0, 32'h2401_0005);
    chk("stray_di",   di0, 32'h0);
    chk("stray_mreq", {31'd0, mreq0}, 32'd0);
    mack = 1'b0;

    // Store plus fetch, data first
    we = 4'hF; DA = 32'h200; DO = 32'hDEAD_BEEF; ireq = 1'b1; PC = 32'h104;
    #1;
    chk("d_c0_hold", {31'd0, hold0}, 32'd1);
    tick();
    chk("d_c1_ma",   ma0, 32'h200);
    chk("d_c1_mw",   {28'd0, mw0}, 32'hF);
    chk("d_c1_mo",   mo0, 32'hDEAD_BEEF);
    chk("d_c1_mreq", {31'd0, mreq0}, 32'd1);
    ireq = 1'b0; we = 4'h0; DA = 32'h999; PC = 32'h888;
    mack = 1'b1; mi0 = 32'h1111_1111; mi1 = 32'h1111_1111;
    tick();
    chk("d_c2_ma",   ma0, 32'h104);
    chk("d_c2_mw",   {28'd0, mw0}, 32'd0);
    chk("d_c2_hold", {31'd0, hold0}, 32'd1);
    mi0 = 32'h8C22_0000; mi1 = 32'h8C22_0000;
    tick();
    chk("d_c3_hold", {31'd0, hold0}, 32'd0);
    chk("d_c3_mreq", {31'd0, mreq0}, 32'd0);
    chk("d_c3_op",   op0, 32'h8C22_0000);
    chk("d_c3_di",   di0, 32'h0);
    mack = 1'b0;
    tick();

    // Load with three wait states
    re = 1'b1; DA = 32'h300;
    tick();
    re = 1'b0; DA = 32'h0000_0999;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      chk("w_ma",   ma0, 32'h300);
      chk("w_hold", {31'd0, hold0}, 32'd1);
      chk("w_mreq", {31'd0, mreq0}, 32'd1);
      chk("w_mw",   {28'd0, mw0}, 32'd0);
    end
    chk("w_di_pre", di0, 32'h0);
    mack = 1'b1; mi0 = 32'h1234_5678; mi1 = 32'h1234_5678;
    tick();
    mack = 1'b0;
    chk("w_di",   di0, 32'h1234_5678);
    chk("w_hold_end", {31'd0, hold0}, 32'd0);
    tick();

    // ireq held high: DONE cycle shows a gap, next IDLE restarts
    ireq = 1'b1; PC = 32'h400; mack = 1'b1; mi0 = 32'h0000_0400; mi1 = 32'h0000_0400;
    tick();
    chk("g_c1_mreq", {31'd0, mreq0}, 32'd1);
    tick();
    chk("g_done_mreq", {31'd0, mreq0}, 32'd0);
    chk("g_done_hold", {31'd0, hold0}, 32'd0);
    tick();
    chk("g_idle_mreq", {31'd0, mreq0}, 32'd0);
    chk("g_idle_hold", {31'd0, hold0}, 32'd1);
    tick();
    chk("g_c4_mreq", {31'd0, mreq0}, 32'd1);
    chk("g_c4_ma",   ma0, 32'h400);
    ireq = 1'b0;
    tick();
    mack = 1'b0;
    tick();

    // Reset while fetch is in flight, then a late mack
    ireq = 1'b1; PC = 32'h500;
    tick();
    chk("r_c1_mreq", {31'd0, mreq0}, 32'd1);
    ireq = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("r_mreq", {31'd0, mreq0}, 32'd0);
    chk("r_hold", {31'd0, hold0}, 32'd0);
    chk("r_op",   op0, 32'h0);
    chk("r_op1",  op1, NOP1);
    chk("r_di",   di0, 32'h0);
    mack = 1'b1; mi0 = 32'h0BAD_BAD0; mi1 = 32'h0BAD_BAD0;
    tick();
    chk("r_late_op",   op0, 32'h0);
    chk("r_late_mreq", {31'd0, mreq0}, 32'd0);
    mack = 1'b0;
    tick();

    // Load plus fetch on both priorities
    ireq = 1'b1; PC = 32'h600; re = 1'b1; DA = 32'h700;
    #1;
    chk("p_c0_hold1", {31'd0, hold1}, 32'd1);
    tick();
    chk("p_c1_ma1", ma1, 32'h600);
    chk("p_c1_mw1", {28'd0, mw1}, 32'd0);
    chk("p_c1_ma0", ma0, 32'h700);
    ireq = 1'b0; re = 1'b0;
    mack = 1'b1; mi1 = 32'hAAAA_0001; mi0 = 32'hDDDD_0002;
    tick();
    chk("p_c2_ma1", ma1, 32'h700);
    chk("p_c2_ma0", ma0, 32'h600);
    mi1 = 32'hDDDD_0001; mi0 = 32'hAAAA_0002;
    tick();
    mack = 1'b0;
    chk("p_op1",   op1, 32'hAAAA_0001);
    chk("p_di1",   di1, 32'hDDDD_0001);
    chk("p_hold1", {31'd0, hold1}, 32'd0);
    chk("p_op0",   op0, 32'hAAAA_0002);
    chk("p_di0",   di0, 32'hDDDD_0002);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
